present_enc_core: RTL and testbench

PRESENT-80 encryption datapath and round controller that consumes the 64-bit round keys produced by the team's key scheduler, and drives that scheduler's load/enable/round-counter inputs. Accepts one plaintext block and an 80-bit key per start handshake, runs 31 rounds plus final whitening, and emits the 64-bit ciphertext with a one-cycle valid pulse. Sits between the top-level block interface and the key scheduler.

---
 rtl/present_enc_core_if.sv | 35 +++
 rtl/present_enc_core.sv | 160 ++++++++++++++++
 tb/tb_present_enc_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/present_enc_core_if.sv
// present_enc_core_if: block handshake and key-scheduler signals of the PRESENT-80 core.
// Ports (core view, slave modport):
//   start, plaintext_in[63:0], key_in[79:0]      block request from the top level
//   ready, ct_valid, ciphertext_out[63:0]        handshake status and result
//   ks_key[79:0], ks_load, ks_enb, ks_count[4:0] controls driven into the key scheduler
//   round_key[63:0]                              round key K_i returned by the scheduler
interface present_enc_core_if;
  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 80;
  localparam int unsigned CNT_W   = 5;

  logic               start;
  logic [BLOCK_W-1:0] plaintext_in;
  logic [KEY_W-1:0]   key_in;
  logic               ready;
  logic               ct_valid;
  logic [BLOCK_W-1:0] ciphertext_out;
  logic [KEY_W-1:0]   ks_key;
  logic               ks_load;
  logic               ks_enb;
  logic [CNT_W-1:0]   ks_count;
  logic [BLOCK_W-1:0] round_key;

  // Requester plus key scheduler side.
  modport master (
    output start, plaintext_in, key_in, round_key,
    input  ready, ct_valid, ciphertext_out, ks_key, ks_load, ks_enb, ks_count
  );

  // Encryption core side.
  modport slave (
    input  start, plaintext_in, key_in, round_key,
    output ready, ct_valid, ciphertext_out, ks_key, ks_load, ks_enb, ks_count
  );
endinterface

// File: rtl/present_enc_core.sv
// present_enc_core: PRESENT-80 encryption datapath and round controller.
// One block per start handshake: LOAD primes the key scheduler, 31 rounds of
// addRoundKey/sBox/pLayer follow, and FINAL whitens with K32 and pulses ct_valid.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  present_enc_core_if.slave (handshake, result, key-scheduler controls)
module present_enc_core (
  input  logic              clk,
  input  logic              rst,
  present_enc_core_if.slave bus
);
  localparam int unsigned BLOCK_W    = 64;
  localparam int unsigned KEY_W      = 80;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned LAST_ROUND = 31;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] FINAL = 2'd3;

  logic [1:0]         fsm_q, fsm_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic               ct_valid_q, ct_valid_d;
  logic               ready_q, ready_d;
  logic [KEY_W-1:0]   ks_key_q, ks_key_d;
  logic               ks_load_q, ks_load_d;
  logic               ks_enb_q, ks_enb_d;
  logic [CNT_W-1:0]   ks_count_q, ks_count_d;

  // 4-bit PRESENT S-box.
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // sBox layer followed by pLayer; bit j lands on (16*j) mod 63, bit 63 is fixed.
  function automatic logic [BLOCK_W-1:0] sp_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] s;
    logic [BLOCK_W-1:0] p;
    for (int unsigned n = 0; n < 16; n++) begin
      s[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    p = '0;
    for (int unsigned j = 0; j < 63; j++) begin
      p[6'((16 * j) % 63)] = s[6'(j)];
    end
    p[63] = s[63];
    return p;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      data_q     <= '0;
      ct_q       <= '0;
      ct_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      ks_key_q   <= '0;
      ks_load_q  <= 1'b0;
      ks_enb_q   <= 1'b0;
      ks_count_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      data_q     <= data_d;
      ct_q       <= ct_d;
      ct_valid_q <= ct_valid_d;
      ready_q    <= ready_d;
      ks_key_q   <= ks_key_d;
      ks_load_q  <= ks_load_d;
      ks_enb_q   <= ks_enb_d;
      ks_count_q <= ks_count_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    fsm_d      = fsm_q;
    data_d     = data_q;
    ct_d       = ct_q;
    ct_valid_d = 1'b0;
    ready_d    = ready_q;
    ks_key_d   = ks_key_q;
    ks_load_d  = 1'b0;
    ks_enb_d   = ks_enb_q;
    ks_count_d = ks_count_q;

    case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          data_d    = bus.plaintext_in;
          ks_key_d  = bus.key_in;
          ks_load_d = 1'b1;
          ready_d   = 1'b0;
          fsm_d     = LOAD;
        end
      end
      LOAD: begin
        ks_enb_d   = 1'b1;
        ks_count_d = CNT_W'(1);
        fsm_d      = ROUND;
      end
      ROUND: begin
        data_d = sp_layer(data_q ^ bus.round_key);
        if (ks_count_q == CNT_W'(LAST_ROUND)) begin
          ks_count_d = '0;
          fsm_d      = FINAL;
        end else begin
          ks_count_d = ks_count_q + CNT_W'(1);
        end
      end
      default: begin
        // FINAL: whiten with K32. The edge that ends FINAL also accepts a new
        // block so back-to-back blocks run every 33 cycles.
        ct_d       = data_q ^ bus.round_key;
        ct_valid_d = 1'b1;
        ks_enb_d   = 1'b0;
        if (bus.start) begin
          data_d    = bus.plaintext_in;
          ks_key_d  = bus.key_in;
          ks_load_d = 1'b1;
          ready_d   = 1'b0;
          fsm_d     = LOAD;
        end else begin
          ready_d = 1'b1;
          fsm_d   = IDLE;
        end
      end
    endcase
  end

  assign bus.ready          = ready_q;
  assign bus.ct_valid       = ct_valid_q;
  assign bus.ciphertext_out = ct_q;
  assign bus.ks_key         = ks_key_q;
  assign bus.ks_load        = ks_load_q;
  assign bus.ks_enb         = ks_enb_q;
  assign bus.ks_count       = ks_count_q;
endmodule

// File: tb/tb_present_enc_core.sv
// tb_present_enc_core: bench for present_enc_core with a behavioural key
// scheduler attached and a loop-based PRESENT-80 reference model.
module tb_present_enc_core;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  present_enc_core_if bus ();

  present_enc_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // One PRESENT-80 key-register update with round counter i.
  function automatic logic [79:0] ks_step(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = SBOX[r[79:76]];
    r[19:15] = r[19:15] ^ i;
    return r;
  endfunction

  // Whole-block reference encryption.
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
      t = '0;
      for (int j = 0; j < 64; j++) t[(j == 63) ? 63 : (j * 16) % 63] = s[j];
      s = t;
      k = ks_step(k, 5'(r));
    end
    return s ^ k[79:16];
  endfunction

  // Key scheduler model: loads on ks_load, emits K_i mid-cycle while ks_enb.
  logic [79:0] ks_reg;
  always @(negedge clk) begin
    if (rst) begin
      ks_reg        <= '0;
      bus.round_key <= '0;
    end else if (bus.ks_load) begin
      ks_reg <= bus.ks_key;
    end else if (bus.ks_enb) begin
      bus.round_key <= ks_reg[79:16];
      ks_reg        <= ks_step(ks_reg, bus.ks_count);
    end
  end

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a request and advance past its accepting edge (core must be ready).
  task automatic launch(input logic [63:0] pt, input logic [79:0] key);
    bus.start        = 1'b1;
    bus.plaintext_in = pt;
    bus.key_in       = key;
    @(posedge clk) #1;
  endtask

  // Called just after accepting edge E0; follows the block to E33 (or E34).
  task automatic run_block(input logic [63:0] pt, input logic [79:0] key, input logic [63:0] exp,
                           input bit noisy, input bit chain,
                           input logic [63:0] npt, input logic [79:0] nkey);
    bus.start        = 1'b0;
    bus.plaintext_in = {$urandom(), $urandom()};
    bus.key_in       = {16'($urandom()), $urandom(), $urandom()};
    check_eq("load_ready", 80'(bus.ready), 80'(0));
    check_eq("load_ks_load", 80'(bus.ks_load), 80'(1));
    check_eq("load_ks_enb", 80'(bus.ks_enb), 80'(0));
    check_eq("load_ks_key", bus.ks_key, key);
    for (int c = 1; c <= 32; c++) begin
      bus.start        = noisy && (c == 6 || c == 21);
      bus.plaintext_in = {$urandom(), $urandom()};
      bus.key_in       = {16'($urandom()), $urandom(), $urandom()};
      @(posedge clk) #1;
      check_eq("rnd_ks_enb", 80'(bus.ks_enb), 80'(1));
      check_eq("rnd_ks_load", 80'(bus.ks_load), 80'(0));
      check_eq("rnd_ks_count", 80'(bus.ks_count), 80'((c <= 31) ? c : 0));
      check_eq("rnd_ready", 80'(bus.ready), 80'(0));
      check_eq("rnd_ct_valid", 80'(bus.ct_valid), 80'(0));
    end
    bus.start = chain;
    if (chain) begin
      bus.plaintext_in = npt;
      bus.key_in       = nkey;
    end
    @(posedge clk) #1;
    check_eq("fin_ct_valid", 80'(bus.ct_valid), 80'(1));
    check_eq("fin_ct", 80'(bus.ciphertext_out), 80'(exp));
    check_eq("fin_ks_enb", 80'(bus.ks_enb), 80'(0));
    check_eq("fin_ready", 80'(bus.ready), 80'(!chain));
    check_eq("fin_ks_load", 80'(bus.ks_load), 80'(chain));
    if (!chain) begin
      bus.start = 1'b0;
      @(posedge clk) #1;
      check_eq("post_ct_valid", 80'(bus.ct_valid), 80'(0));
      check_eq("post_ct_hold", 80'(bus.ciphertext_out), 80'(exp));
      check_eq("post_ready", 80'(bus.ready), 80'(1));
    end
  endtask

  initial begin
    logic [63:0] pt, pt2;
    logic [79:0] key, key2;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.start        = 1'b0;
    bus.plaintext_in = '0;
    bus.key_in       = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_ready", 80'(bus.ready), 80'(1));
    check_eq("rst_ct_valid", 80'(bus.ct_valid), 80'(0));
    check_eq("rst_ct", 80'(bus.ciphertext_out), 80'(0));
    check_eq("rst_ks_key", bus.ks_key, 80'(0));
    check_eq("rst_ks_load", 80'(bus.ks_load), 80'(0));
    check_eq("rst_ks_enb", 80'(bus.ks_enb), 80'(0));
    check_eq("rst_ks_count", 80'(bus.ks_count), 80'(0));

    // Known-answer vectors.
    launch(64'h0, 80'h0);
    run_block(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, 1'b0, '0, '0);
    launch(64'h0, {80{1'b1}});
    run_block(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, 1'b0, '0, '0);
    launch({64{1'b1}}, 80'h0);
    run_block({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0, 1'b0, '0, '0);
    launch({64{1'b1}}, {80{1'b1}});
    run_block({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0, 1'b0, '0, '0);

    // Back-to-back: second block accepted at E33, result at E66.
    pt2  = {$urandom(), $urandom()};
    key2 = {16'($urandom()), $urandom(), $urandom()};
    launch(64'h0, 80'h0);
    run_block(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, 1'b1, pt2, key2);
    run_block(pt2, key2, ref_enc(pt2, key2), 1'b0, 1'b0, '0, '0);

    // Start pulses during rounds 5 and 20 are ignored.
    pt  = {$urandom(), $urandom()};
    key = {16'($urandom()), $urandom(), $urandom()};
    launch(pt, key);
    run_block(pt, key, ref_enc(pt, key), 1'b1, 1'b0, '0, '0);

    // Reset abort at round 12.
    pt  = {$urandom(), $urandom()};
    key = {16'($urandom()), $urandom(), $urandom()};
    launch(pt, key);
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    check_eq("abort_ct_valid", 80'(bus.ct_valid), 80'(0));
    check_eq("abort_ct", 80'(bus.ciphertext_out), 80'(0));
    check_eq("abort_ks_enb", 80'(bus.ks_enb), 80'(0));
    check_eq("abort_ks_load", 80'(bus.ks_load), 80'(0));
    check_eq("abort_ks_count", 80'(bus.ks_count), 80'(0));
    check_eq("abort_ks_key", bus.ks_key, 80'(0));
    check_eq("abort_ready", 80'(bus.ready), 80'(1));
    for (int c = 0; c < 25; c++) begin
      @(posedge clk) #1;
      check_eq("abort_quiet", 80'({bus.ct_valid, bus.ks_enb, bus.ks_load}), 80'(0));
    end
    launch(64'h0, 80'h0);
    run_block(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, 1'b0, '0, '0);

    // Random blocks against the reference model.
    for (int b = 0; b < 4; b++) begin
      pt  = {$urandom(), $urandom()};
      key = {16'($urandom()), $urandom(), $urandom()};
      launch(pt, key);
      run_block(pt, key, ref_enc(pt, key), 1'b0, 1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
